fractal_sync_tx: RTL and testbench



---
 rtl/fractal_sync_pkg.sv | 26 ++
 rtl/fractal_sync_rr_arb.sv | 43 ++++
 rtl/fractal_sync_tx.sv | 67 ++++++
 tb/tb_fractal_sync_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared request types and sizing helpers for the fractal synchronization tree.
package fractal_sync_pkg;

   localparam int AGGR_W = 2;
   localparam int ID_W   = 4;

   typedef struct packed {
      logic [AGGR_W-1:0] aggr;
      logic [ID_W-1:0]   id;
   } fsync_sig_t;

   typedef struct packed {
      logic       sync;
      fsync_sig_t sig;
   } fsync_req_t;

   // A counter that can hold 0..credits inclusive.
   function automatic int credit_width(input int credits);
      return $clog2(credits + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module fractal_sync_rr_arb
   import fractal_sync_pkg::*;
#(
   parameter int N_PORTS = 2,
   localparam int IDX_W  = idx_width(N_PORTS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_PORTS-1:0] req_i,
   input  logic               en_i,
   output logic [N_PORTS-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               vld_o
);

   logic [IDX_W-1:0] ptr_q;
   logic             found;

   always_comb begin
      found = 1'b0;
      idx_o = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!found && req_i[(int'(ptr_q) + i) % N_PORTS]) begin
            found = 1'b1;
            idx_o = IDX_W'((int'(ptr_q) + i) % N_PORTS);
         end
      end
      vld_o = found && en_i && !rst_i;
      gnt_o = '0;
      if (vld_o) gnt_o[idx_o] = 1'b1;
   end

   // With a single port the wrap branch is always taken, so the pointer stays 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (vld_o) begin
         ptr_q <= (int'(idx_o) == N_PORTS - 1) ? '0 : idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/fractal_sync_tx.sv
// Transmit stage: arbitrates rx FIFOs and forwards one credited request per cycle upstream.
module fractal_sync_tx
   import fractal_sync_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int CREDITS = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic       [N_PORTS-1:0] empty_i,
   input  fsync_req_t [N_PORTS-1:0] req_i,
   output logic       [N_PORTS-1:0] pop_o,
   output fsync_req_t               req_o,
   input  logic                     credit_i,
   output logic                     stall_o,
   output logic                     error_credit_o
);

   localparam int CNT_W = credit_width(CREDITS);
   localparam int IDX_W = idx_width(N_PORTS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

   if (N_PORTS < 1) begin : g_chk_ports
      $fatal(1, "fractal_sync_tx: N_PORTS must be >= 1");
   end
   if (CREDITS < 1) begin : g_chk_credits
      $fatal(1, "fractal_sync_tx: CREDITS must be > 0");
   end

   logic [CNT_W-1:0] cnt_q;
   logic             gnt_vld_p0;
   logic [IDX_W-1:0] gnt_idx_p0;

   fractal_sync_rr_arb #(
      .N_PORTS (N_PORTS)
   ) i_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (~empty_i),
      .en_i  (cnt_q != '0),
      .gnt_o (pop_o),
      .idx_o (gnt_idx_p0),
      .vld_o (gnt_vld_p0)
   );

   assign stall_o = !rst_i && (|(~empty_i)) && (cnt_q == '0);

   // p0 -> p1: grant registered into the upstream pulse; sig is held between pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q          <= CNT_MAX;
         req_o          <= '0;
         error_credit_o <= 1'b0;
      end else begin
         req_o.sync     <= gnt_vld_p0;
         if (gnt_vld_p0) req_o.sig <= req_i[gnt_idx_p0].sig;
         error_credit_o <= 1'b0;
         if (gnt_vld_p0 && !credit_i) begin
            cnt_q <= cnt_q - 1'b1;
         end else if (!gnt_vld_p0 && credit_i) begin
            if (cnt_q == CNT_MAX) error_credit_o <= 1'b1;
            else                  cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Scenario bench for fractal_sync_tx against a cycle-level reference model of the arbitration and credit rules.
module tb_fractal_sync_tx;
   import fractal_sync_pkg::*;

   localparam int N     = 2;
   localparam int CR    = 2;
   localparam int REQ_W = N * $bits(fsync_req_t);
   typedef fsync_req_t [N-1:0] req_vec_t;

   logic       clk = 1'b0;
   logic       rst_i, credit_i, stall_o, error_credit_o;
   logic [N-1:0] empty_i, pop_o;
   req_vec_t   req_i;
   fsync_req_t req_o;

   fractal_sync_tx #(.N_PORTS(N), .CREDITS(CR)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .empty_i        (empty_i),
      .req_i          (req_i),
      .pop_o          (pop_o),
      .req_o          (req_o),
      .credit_i       (credit_i),
      .stall_o        (stall_o),
      .error_credit_o (error_credit_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: values expected after the coming clock edge.
   int         m_cnt, m_ptr;
   logic       m_err, m_sync;
   fsync_sig_t m_sig;
   logic [N-1:0] exp_pop;
   logic       exp_stall;
   fsync_req_t exp_req;

   function automatic req_vec_t rnd_req();
      return REQ_W'($urandom);
   endfunction

   task automatic drive(input logic [N-1:0] e, input req_vec_t r, input logic c, input logic rs);
      int g;
      empty_i = e; req_i = r; credit_i = c; rst_i = rs;
      #1;
      exp_pop = '0; exp_stall = 1'b0; g = -1;
      if (rs) begin
         m_cnt = CR; m_ptr = 0; m_sync = 1'b0; m_sig = '0; m_err = 1'b0;
      end else begin
         exp_stall = (e != '1) && (m_cnt == 0);
         if (m_cnt > 0)
            for (int i = 0; i < N; i++)
               if (g < 0 && !e[(m_ptr + i) % N]) g = (m_ptr + i) % N;
         m_err  = 1'b0;
         m_sync = (g >= 0);
         if (g >= 0) begin
            exp_pop[g] = 1'b1;
            m_sig      = r[g].sig;
            m_ptr      = (g + 1) % N;
         end
         if (g >= 0 && !c) m_cnt--;
         else if (g < 0 && c) begin
            if (m_cnt == CR) m_err = 1'b1;
            else             m_cnt++;
         end
      end
      exp_req.sync = m_sync;
      exp_req.sig  = m_sig;
   endtask

   task automatic apply_reset();
      drive('1, '0, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive('0, rnd_req(), 1'b1, 1'b1);
         checks++;
         if ({pop_o, stall_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb: pop=%b stall=%b, expected pop=00 stall=0", pop_o, stall_o);
         end
         @(negedge clk);
         checks++;
         if (req_o !== '0 || error_credit_o !== 1'b0 || int'(dut.cnt_q) !== CR) begin
            errors++;
            $display("FAIL reset_regs: req=%h err=%b cnt=%0d, expected req=0 err=0 cnt=%0d",
                     req_o, error_credit_o, dut.cnt_q, CR);
         end
      end
   endtask

   task automatic test_single();
      req_vec_t r;
      r = rnd_req();
      r[0].sig.id = 4'd5; r[0].sig.aggr = 2'd3;
      drive(2'b10, r, 1'b0, 1'b0);
      checks++;
      if (pop_o !== 2'b01 || {pop_o, stall_o} !== {exp_pop, exp_stall}) begin
         errors++;
         $display("FAIL single_comb: pop=%b stall=%b, expected pop=01 stall=%b", pop_o, stall_o, exp_stall);
      end
      @(negedge clk);
      checks++;
      if (req_o.sync !== 1'b1 || req_o.sig.id !== 4'd5 || req_o.sig.aggr !== 2'd3 ||
          int'(dut.cnt_q) !== 1 || {req_o, error_credit_o} !== {exp_req, m_err}) begin
         errors++;
         $display("FAIL single_regs: sync=%b id=%0d aggr=%0d cnt=%0d, expected sync=1 id=5 aggr=3 cnt=1",
                  req_o.sync, req_o.sig.id, req_o.sig.aggr, dut.cnt_q);
      end
      drive(2'b11, rnd_req(), 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if ({req_o, error_credit_o} !== {exp_req, m_err} || int'(dut.cnt_q) !== m_cnt) begin
         errors++;
         $display("FAIL single_refill: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                  req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0] prev_pop;
      prev_pop = '0;
      for (int i = 0; i < 8; i++) begin
         drive(2'b00, rnd_req(), (i > 0), 1'b0);
         checks++;
         if ({pop_o, stall_o} !== {exp_pop, exp_stall} || pop_o == 2'b00 ||
             (i > 0 && pop_o !== ~prev_pop)) begin
            errors++;
            $display("FAIL alternate_comb cyc %0d: pop=%b stall=%b, expected pop=%b stall=%b",
                     i, pop_o, stall_o, exp_pop, exp_stall);
         end
         prev_pop = pop_o;
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || req_o.sync !== 1'b1 ||
             int'(dut.cnt_q) !== m_cnt) begin
            errors++;
            $display("FAIL alternate_regs cyc %0d: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                     i, req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_stall();
      int entries;
      apply_reset();
      entries = 3;
      for (int c = 0; c < 8; c++) begin
         drive({1'b1, entries == 0}, rnd_req(), (c == 4), 1'b0);
         checks++;
         if ({pop_o, stall_o} !== {exp_pop, exp_stall} ||
             (c == 2 && stall_o !== 1'b1) || (c == 5 && pop_o !== 2'b01)) begin
            errors++;
            $display("FAIL stall_comb cyc %0d: pop=%b stall=%b, expected pop=%b stall=%b",
                     c, pop_o, stall_o, exp_pop, exp_stall);
         end
         if (exp_pop[0]) entries--;
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || int'(dut.cnt_q) !== m_cnt ||
             (c == 5 && req_o.sync !== 1'b1)) begin
            errors++;
            $display("FAIL stall_regs cyc %0d: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                     c, req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_credit_same_cycle();
      for (int c = 0; c < 2; c++) begin
         drive(2'b10, rnd_req(), (c == 0), 1'b0);
         checks++;
         if ({pop_o, stall_o} !== {exp_pop, exp_stall} || pop_o !== ((c == 0) ? 2'b00 : 2'b01)) begin
            errors++;
            $display("FAIL samecyc_comb cyc %0d: pop=%b stall=%b, expected pop=%b stall=%b",
                     c, pop_o, stall_o, exp_pop, exp_stall);
         end
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || int'(dut.cnt_q) !== m_cnt) begin
            errors++;
            $display("FAIL samecyc_regs cyc %0d: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                     c, req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, rnd_req(), (c == 0), 1'b0);
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || error_credit_o !== (c == 0) ||
             int'(dut.cnt_q) !== CR) begin
            errors++;
            $display("FAIL overflow cyc %0d: err=%b cnt=%0d, expected err=%b cnt=%0d",
                     c, error_credit_o, dut.cnt_q, (c == 0), CR);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b00, rnd_req(), 1'b0, (c == 1));
         checks++;
         if ({pop_o, stall_o} !== {exp_pop, exp_stall} || (c != 1 && pop_o !== 2'b01)) begin
            errors++;
            $display("FAIL reset_mid_comb cyc %0d: pop=%b stall=%b, expected pop=%b stall=%b",
                     c, pop_o, stall_o, exp_pop, exp_stall);
         end
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || int'(dut.cnt_q) !== m_cnt) begin
            errors++;
            $display("FAIL reset_mid_regs cyc %0d: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                     c, req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         drive(N'($urandom), rnd_req(), ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
         checks++;
         if ({pop_o, stall_o} !== {exp_pop, exp_stall}) begin
            errors++;
            $display("FAIL random_comb cyc %0d: pop=%b stall=%b, expected pop=%b stall=%b",
                     c, pop_o, stall_o, exp_pop, exp_stall);
         end
         @(negedge clk);
         checks++;
         if ({req_o, error_credit_o} !== {exp_req, m_err} || int'(dut.cnt_q) !== m_cnt) begin
            errors++;
            $display("FAIL random_regs cyc %0d: req=%h err=%b cnt=%0d, expected req=%h err=%b cnt=%0d",
                     c, req_o, error_credit_o, dut.cnt_q, exp_req, m_err, m_cnt);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i = 1'b1; empty_i = '1; req_i = '0; credit_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_alternate();
      test_stall();
      test_credit_same_cycle();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
